morse_encoder: RTL and testbench

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_encoder.sv | 153 +++++++++++++++
 tb/tb_morse_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse encoder for letters A-H: lights led for each dot/dash and pulses done.
// First mark begins on the first tick after the start rise; start rises while busy are dropped.
module morse_encoder #(
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] letter,
  input  logic       start,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ALIGN, MARK, GAP} state_t;

  localparam logic [2:0] DOT_M1  = 3'(DOT_UNITS - 1);
  localparam logic [2:0] DASH_M1 = 3'(DASH_UNITS - 1);
  localparam logic [2:0] GAP_M1  = 3'(GAP_UNITS - 1);

  state_t     state, state_nxt;
  logic       start_q;
  logic       rise;
  logic [2:0] cnt, cnt_nxt;
  logic [1:0] idx, idx_nxt;
  logic [1:0] idx_inc;
  logic [3:0] pat, pat_nxt;
  logic [2:0] len, len_nxt;
  logic       led_q, led_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic [3:0] tbl_pat;
  logic [2:0] tbl_len;
  logic       last_sym;

  assign rise     = start & ~start_q;
  assign idx_inc  = idx + 2'd1;
  assign last_sym = ({1'b0, idx} == (len - 3'd1));

  function automatic logic [2:0] unit_m1(input logic is_dash);
    return is_dash ? DASH_M1 : DOT_M1;
  endfunction

  // Pattern bit i is symbol i (1 = dash), first symbol in bit 0.
  always_comb begin : code_table
    tbl_pat = 4'b0000;
    tbl_len = 3'd1;
    case (letter)
      3'd0: begin tbl_pat = 4'b0010; tbl_len = 3'd2; end
      3'd1: begin tbl_pat = 4'b0001; tbl_len = 3'd4; end
      3'd2: begin tbl_pat = 4'b0101; tbl_len = 3'd4; end
      3'd3: begin tbl_pat = 4'b0001; tbl_len = 3'd3; end
      3'd4: begin tbl_pat = 4'b0000; tbl_len = 3'd1; end
      3'd5: begin tbl_pat = 4'b0100; tbl_len = 3'd4; end
      3'd6: begin tbl_pat = 4'b0011; tbl_len = 3'd3; end
      3'd7: begin tbl_pat = 4'b0000; tbl_len = 3'd4; end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin : state_reg
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= 3'd0;
      idx     <= 2'd0;
      pat     <= 4'd0;
      len     <= 3'd1;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      pat     <= pat_nxt;
      len     <= len_nxt;
      led_q   <= led_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    pat_nxt   = pat;
    len_nxt   = len;
    led_nxt   = led_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A tick coinciding with acceptance is deliberately not consumed.
        if (rise) begin
          pat_nxt   = tbl_pat;
          len_nxt   = tbl_len;
          idx_nxt   = 2'd0;
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (tick) begin
          led_nxt   = 1'b1;
          cnt_nxt   = unit_m1(pat[idx]);
          state_nxt = MARK;
        end
      end
      MARK: begin
        if (tick) begin
          if (cnt == 3'd0) begin
            led_nxt   = 1'b0;
            cnt_nxt   = GAP_M1;
            state_nxt = GAP;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
          end else if (!last_sym) begin
            idx_nxt   = idx_inc;
            led_nxt   = 1'b1;
            cnt_nxt   = unit_m1(pat[idx_inc]);
            state_nxt = MARK;
          end else begin
            idx_nxt   = 2'd0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin : outputs
    led  = led_q;
    busy = busy_q;
    done = done_q;
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: led run lengths measured per transmission and compared
// with timings derived from the dot/dash table and the tick period.
module tb_morse_encoder;

  localparam int DOT  = 1;
  localparam int DASH = 3;
  localparam int GAP  = 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       start = 1'b0;
  logic       led, busy, done;

  int    checks = 0;
  int    errors = 0;
  int    period = 8;
  int    phase = 0;
  int    got_q[$];
  int    exp_q[$];
  int    align_got, exp_align, busy_cnt;
  bit    done_seen, done_busy, done_after, acc_busy, acc_led;
  string codes[8];

  morse_encoder #(.DOT_UNITS(DOT), .DASH_UNITS(DASH), .GAP_UNITS(GAP)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .letter(letter),
    .start(start), .led(led), .busy(busy), .done(done)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  // Expected alternating mark/dark lengths in cycles.
  function automatic void model_runs(input int l, input int p);
    byte c;
    exp_q.delete();
    for (int i = 0; i < codes[l].len(); i++) begin
      c = codes[l][i];
      exp_q.push_back(((c == "-") ? DASH : DOT) * p);
      exp_q.push_back(GAP * p);
    end
  endfunction

  function automatic int sum_exp();
    int s = 0;
    foreach (exp_q[i]) s += exp_q[i];
    return s;
  endfunction

  task automatic step();
    tick = (phase == period - 1);
    @(posedge CLOCK_50);
    #1;
    phase = (phase + 1) % period;
  endtask

  // Accept edge, then measure led runs until done; optionally disturb start/letter mid-run.
  task automatic run_tx(input int disturb_at, input bit hold);
    int  n, len;
    bit  cur, started;
    step();
    acc_busy  = busy;
    acc_led   = led;
    exp_align = period - phase;
    align_got = 1;
    busy_cnt  = busy ? 1 : 0;
    got_q.delete();
    started = 0; cur = 0; len = 0; n = 0;
    done_seen = 0; done_busy = 0;
    if (!hold) start = 1'b0;
    while (!done_seen && n < 600) begin
      if (n == disturb_at) begin start = 1'b1; letter = 3'd1; end
      if (n == disturb_at + 2) start = 1'b0;
      step();
      n++;
      if (done) begin
        done_seen = 1;
        done_busy = busy;
        if (started) got_q.push_back(len);
      end else begin
        if (busy) busy_cnt++;
        if (!started) begin
          if (led) begin started = 1; cur = 1; len = 1; end
          else align_got++;
        end else if (led == cur) begin
          len++;
        end else begin
          got_q.push_back(len);
          cur = led;
          len = 1;
        end
      end
    end
    step();
    done_after = done;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; period = 8; phase = 0;
    repeat (3) step();
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b expected 0", led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    reset = 1'b0;
    repeat (10) step();
    checks++; if (busy !== 1'b0 || led !== 1'b0) begin errors++; $display("FAIL idle_quiet got busy=%b led=%b expected 0 0", busy, led); end
  endtask

  task automatic test_letter_a();
    period = 8; phase = $urandom_range(0, 7); letter = 3'd0; start = 1'b1;
    run_tx(-10, 0);
    model_runs(0, 8);
    checks++; if (acc_busy !== 1'b1) begin errors++; $display("FAIL a_accept_busy got %b expected 1", acc_busy); end
    checks++; if (align_got != exp_align) begin errors++; $display("FAIL a_align got %0d expected %0d", align_got, exp_align); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL a_run_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL a_run%0d got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (!done_seen || done_busy) begin errors++; $display("FAIL a_done got seen=%b busy=%b expected 1 0", done_seen, done_busy); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL a_done_width got %b expected 0", done_after); end
  endtask

  task automatic test_letter_e();
    period = 8; phase = $urandom_range(0, 7); letter = 3'd4; start = 1'b1;
    run_tx(-10, 0);
    model_runs(4, 8);
    checks++; if (got_q.size() != 2 || got_q[0] != 8 || got_q[1] != 8) begin errors++; $display("FAIL e_runs got %0d runs expected 2 runs of 8", got_q.size()); end
    checks++; if (busy_cnt != align_got + 16) begin errors++; $display("FAIL e_busy_time got %0d expected %0d", busy_cnt, align_got + 16); end
    checks++; if (!done_seen || done_after) begin errors++; $display("FAIL e_done got seen=%b after=%b expected 1 0", done_seen, done_after); end
  endtask

  task automatic test_random_letters();
    int l;
    for (int k = 0; k < 12; k++) begin
      period = $urandom_range(2, 9);
      phase  = $urandom_range(0, period - 1);
      repeat ($urandom_range(0, 3)) step();
      l = $urandom_range(0, 7);
      letter = 3'(l); start = 1'b1;
      run_tx(($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : -10, 0);
      model_runs(l, period);
      checks++; if (align_got != exp_align) begin errors++; $display("FAIL rnd%0d_align got %0d expected %0d", k, align_got, exp_align); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_run_count letter %0d got %0d expected %0d", k, l, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rnd%0d_run%0d got %0d expected %0d", k, i, got_q[i], exp_q[i]); end
      end
      checks++; if (busy_cnt != align_got + sum_exp()) begin errors++; $display("FAIL rnd%0d_busy_time got %0d expected %0d", k, busy_cnt, align_got + sum_exp()); end
      checks++; if (!done_seen || done_busy || done_after) begin errors++; $display("FAIL rnd%0d_done got seen=%b busy=%b after=%b expected 1 0 0", k, done_seen, done_busy, done_after); end
    end
  endtask

  task automatic test_ignore_while_busy();
    period = 8; phase = 0; letter = 3'd7; start = 1'b1;
    run_tx(20, 0);
    model_runs(7, 8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL h_run_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL h_run%0d got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (!done_seen || done_after || busy) begin errors++; $display("FAIL h_single_done got seen=%b after=%b busy=%b expected 1 0 0", done_seen, done_after, busy); end
  endtask

  task automatic test_start_with_tick();
    int l;
    period = 8; phase = 7; l = $urandom_range(0, 7); letter = 3'(l); start = 1'b1;
    run_tx(-10, 0);
    model_runs(l, 8);
    checks++; if (acc_led !== 1'b0) begin errors++; $display("FAIL st_led_at_accept got %b expected 0", acc_led); end
    checks++; if (align_got != 8) begin errors++; $display("FAIL st_align got %0d expected 8", align_got); end
    checks++; if (got_q.size() != exp_q.size() || (got_q.size() > 0 && got_q[0] != exp_q[0])) begin errors++; $display("FAIL st_runs got %0d runs expected %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int rises, dn, bz, n;
    bit prev;
    period = 8; phase = 0; letter = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    rises = 0; prev = led; n = 0;
    while (rises < 2 && n < 200) begin
      step(); n++;
      if (led && !prev) rises++;
      prev = led;
    end
    repeat (3) step();
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL rm_in_mark got %b expected 1", led); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_abort got led=%b busy=%b done=%b expected 0 0 0", led, busy, done); end
    dn = 0; bz = 0;
    repeat (80) begin step(); if (done) dn++; if (busy || led) bz++; end
    checks++; if (dn != 0 || bz != 0) begin errors++; $display("FAIL rm_no_done got done=%0d active=%0d expected 0 0", dn, bz); end
    letter = 3'd2; start = 1'b1;
    run_tx(-10, 0);
    model_runs(2, 8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_c_run_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rm_c_run%0d got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_through_reset();
    int bz;
    period = 8; phase = 0; letter = 3'd3; start = 1'b1; reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    run_tx(-10, 1);
    model_runs(3, 8);
    checks++; if (acc_busy !== 1'b1) begin errors++; $display("FAIL sr_accept got %b expected 1", acc_busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sr_run_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL sr_run%0d got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    bz = 0;
    repeat (60) begin step(); if (busy) bz++; end
    checks++; if (bz != 0) begin errors++; $display("FAIL sr_no_retrigger got %0d busy cycles expected 0", bz); end
    start = 1'b0;
    step();
  endtask

  initial begin
    codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    test_reset();
    test_letter_a();
    test_letter_e();
    test_start_with_tick();
    test_ignore_while_busy();
    test_reset_mid();
    test_start_through_reset();
    test_random_letters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
